// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch PC controller.
package fetch_pkg;

   // Fetch sequencer states; 2-bit encoding
   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP  = 32'h0000_0004;
   localparam logic [31:0] NOP          = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_buf.sv
// One-entry holding register for a redirect that arrives while a fetch is
// still outstanding. A simultaneous set and clear keeps the new target.
module fetch_redirect_buf #(
   parameter int unsigned AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set,
   input  logic [AW-1:0] set_pc,
   input  logic          clr,
   output logic          valid,
   output logic [AW-1:0] pc
);

   logic          valid_r;
   logic [AW-1:0] pc_r;

   // Capture a pending redirect target; set has priority over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         pc_r    <= {AW{1'b0}};
      end else if (set) begin
         valid_r <= 1'b1;
         pc_r    <= set_pc;
      end else if (clr) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign valid = valid_r;
   assign pc    = pc_r;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Program counter sequencer for a single-outstanding request/ack instruction
// fetch. Redirects override sequential increment; a fetch made stale by a
// redirect is discarded when its ack returns and counted in squash_cnt.
module fetch_pc_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned   AW       = 32,
   parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
   parameter logic [AW-1:0] PC_STEP  = AW'(DEF_PC_STEP)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic          stall,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [31:0]   imem_rdata,
   output logic          if_valid,
   output logic [AW-1:0] if_pc,
   output logic [31:0]   if_instr,
   input  logic          if_ready,
   output logic [15:0]   squash_cnt
);

   state_t        state_r, state_next_s;
   logic [AW-1:0] pc_r, pc_next_s;
   logic          imem_req_r;
   logic          if_valid_r, if_valid_next_s;
   logic [AW-1:0] if_pc_r, if_pc_next_s;
   logic [31:0]   if_instr_r, if_instr_next_s;
   logic [15:0]   squash_r, squash_next_s;
   logic          squash_inc_s;

   logic [AW-1:0] redir_pc_s;
   logic          pend_set_s, pend_clr_s, pend_valid_s;
   logic [AW-1:0] pend_pc_s;

   // Targets are word aligned; the low two bits are dropped
   assign redir_pc_s = redirect_pc & ~AW'(3);

   // A redirect during an outstanding request is parked until the ack; the
   // address on the bus must not move mid-request
   assign pend_set_s = (state_r == S_REQ) && redirect && !imem_ack;
   assign pend_clr_s = (state_r == S_REQ) && imem_ack;

   fetch_redirect_buf #(.AW(AW)) u_redirect_buf (
      .clk    (clk),
      .rst    (rst),
      .set    (pend_set_s),
      .set_pc (redir_pc_s),
      .clr    (pend_clr_s),
      .valid  (pend_valid_s),
      .pc     (pend_pc_s)
   );

   // Next-state, next-PC and fetch-output decode
   always_comb begin
      state_next_s    = state_r;
      pc_next_s       = pc_r;
      if_valid_next_s = if_valid_r;
      if_pc_next_s    = if_pc_r;
      if_instr_next_s = if_instr_r;
      squash_inc_s    = 1'b0;
      case (state_r)
         S_BOOT: begin
            state_next_s = S_REQ;
         end
         S_REQ: begin
            if (imem_ack) begin
               if (pend_valid_s || redirect) begin
                  // Stale fetch: drop data, newest redirect target wins
                  squash_inc_s = 1'b1;
                  if (redirect) begin
                     pc_next_s = redir_pc_s;
                  end else begin
                     pc_next_s = pend_pc_s;
                  end
               end else begin
                  if_instr_next_s = imem_rdata;
                  if_pc_next_s    = pc_r;
                  if_valid_next_s = 1'b1;
                  pc_next_s       = pc_r + PC_STEP;
                  state_next_s    = S_OUT;
               end
            end else begin
               state_next_s = S_REQ;
            end
         end
         S_OUT: begin
            if (redirect) begin
               // Redirect overrides stall and drops the held instruction
               if_valid_next_s = 1'b0;
               pc_next_s       = redir_pc_s;
               squash_inc_s    = 1'b1;
               state_next_s    = S_REQ;
            end else if (if_ready && !stall) begin
               if_valid_next_s = 1'b0;
               state_next_s    = S_REQ;
            end else begin
               state_next_s = S_OUT;
            end
         end
         default: begin
            state_next_s    = S_BOOT;
            if_valid_next_s = 1'b0;
         end
      endcase
   end

   // Saturating squash counter increment
   always_comb begin
      if (squash_inc_s && (squash_r != 16'hFFFF)) begin
         squash_next_s = squash_r + 16'd1;
      end else begin
         squash_next_s = squash_r;
      end
   end

   // State, PC and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_BOOT;
         pc_r       <= RESET_PC;
         imem_req_r <= 1'b0;
         if_valid_r <= 1'b0;
         if_pc_r    <= {AW{1'b0}};
         if_instr_r <= NOP;
         squash_r   <= 16'h0000;
      end else begin
         state_r    <= state_next_s;
         pc_r       <= pc_next_s;
         imem_req_r <= (state_next_s == S_REQ);
         if_valid_r <= if_valid_next_s;
         if_pc_r    <= if_pc_next_s;
         if_instr_r <= if_instr_next_s;
         squash_r   <= squash_next_s;
      end
   end

   // Request is only raised in S_REQ, where pc_r is the fetch address
   assign imem_req   = imem_req_r;
   assign imem_addr  = pc_r;
   assign if_valid   = if_valid_r;
   assign if_pc      = if_pc_r;
   assign if_instr   = if_instr_r;
   assign squash_cnt = squash_r;

endmodule
